sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//   Parametrised single-clock FIFO, successor to the basic 8x8 FIFO.
//   Adds configurable width/depth, almost-full/almost-empty thresholds, an occupancy count output,
//   and sticky overflow/underflow error flags.
//   Optional first-word-fall-through (FWFT) read mode.
//   Sits between producer/consumer stages in one clock domain; no CDC.
// PARAMETERS
//   WIDTH      8         data word width in bits (>=1)
//   DEPTH      16        number of entries; power of 2, >=2
//   AF_THRESH  DEPTH-2   almost_full asserted when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  2         almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//   clk           in   1                  clock, all logic on rising edge
//   arst_n        in   1                  asynchronous active-low reset
//   wr_en         in   1                  write request
//   data_in       in   WIDTH              write data
//   rd_en         in   1                  read request (FWFT: acknowledge of head word)
//   data_out      out  WIDTH              read data
//   full          out  1                  count == DEPTH
//   empty         out  1                  count == 0
//   almost_full   out  1                  count >= AF_THRESH
//   almost_empty  out  1                  count <= AE_THRESH
//   count         out  $clog2(DEPTH)+1    current occupancy, 0..DEPTH
//   overflow      out  1                  sticky: write attempted while full
//   underflow     out  1                  sticky: read attempted while empty
//   clr_err       in   1                  synchronous clear of overflow/underflow
// BEHAVIOUR
//   - Reset (async assert, sync-to-clk deassert by system): write_ptr=read_ptr=0, count=0,
//     data_out=0, overflow=underflow=0, so empty=1, almost_empty=1, full=0, almost_full=0.
//     Memory is not reset.
//     Reset mid-operation discards all contents; flags take reset values immediately.
//   - Accepted write: wr_accept = wr_en && !full.
//     mem[write_ptr] <= data_in; write_ptr += 1.
//   - Accepted read: rd_accept = rd_en && !empty. read_ptr += 1.
//   - No write bypass when full: wr_en && full is dropped even if rd_accept is high the same cycle.
//   - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//   - count: +1 on wr_accept only, -1 on rd_accept only, unchanged when both or neither.
//     Never exceeds DEPTH, never below 0.
//   - full, empty, almost_full and almost_empty are combinational decodes of the registered count.
//     They update the cycle after the accepted op.
//   - overflow <= 1 on wr_en && full; underflow <= 1 on rd_en && empty.
//     Both cleared by clr_err. A set condition wins over clr_err in the same cycle.
//   - Rejected ops (write when full, read when empty) change no pointer, count or memory.
// CONFIGURATION
//   FIFO_FWFT_EN undefined (standard mode):
//     - data_out is registered, loaded with mem[read_ptr] on rd_accept.
//     - Valid 1 cycle after rd_en. Holds its value otherwise.
//   FIFO_FWFT_EN defined:
//     - data_out = mem[read_ptr] whenever !empty, so the head word is visible before rd_en.
//     - rd_en pops it; the next word appears the following cycle.
//     - data_out = 0 while empty. First write is visible on data_out 1 cycle after wr_accept.
// TESTING
//   1. After reset, write 0x00..0x0F (DEPTH=16):
//      - almost_full=1 from count=14; full=1 and count=16 after the 16th write.
//      - almost_empty=0 from count=3.
//   2. At full, wr_en with 0xAA:
//      - overflow=1; count stays 16; 0xAA is never read back.
//      - clr_err pulse -> overflow=0 next cycle.
//   3. Drain 16 reads:
//      - Standard mode: data_out = 0x00..0x0F, each 1 cycle after rd_en.
//      - FWFT mode: the head word is visible before rd_en.
//      - empty=1 after the last read.
//   4. At count=5, simultaneous wr_en(0x55) and rd_en:
//      - count stays 5; FIFO order preserved; 0x55 is read out 5th.
//   5. When empty, rd_en=1:
//      - underflow=1; read_ptr and count stable; data_out holds (standard mode).
//      - Simultaneous underflow and clr_err -> underflow=1.
//   6. Run 40 interleaved writes/reads so both pointers wrap twice; assert arst_n=0 at count=7:
//      - Read data matches write order across the wrap.
//      - After reset: count=0, empty=1, all flags at reset values.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised single-clock FIFO with threshold flags, count and sticky errors (FIFO_FWFT_EN selects first-word-fall-through)
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept;
    logic          rd_accept;

    // Status flags decode the registered occupancy, so they trail the accepted op by one cycle.
    always_comb begin
        full         = (count_q == DEPTH_C);
        empty        = (count_q == '0);
        almost_full  = (count_q >= AF_C);
        almost_empty = (count_q <= AE_C);
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        // A write into a full FIFO is dropped even when a read frees a slot in the same cycle.
        wr_accept    = wr_en && !full;
        rd_accept    = rd_en && !empty;
    end

    // Next-state for pointers, occupancy and sticky error flags (a new error beats clr_err).
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register; reset discards contents by zeroing pointers and count.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally while the FIFO holds data; rd_en only pops it.
    always_comb begin
        data_out = empty ? '0 : mem_q[rd_ptr_q];
    end
`else
    logic [WIDTH-1:0] data_out_q, data_out_d;

    // Output register loads the head word on an accepted read and holds otherwise.
    always_comb begin
        data_out_d = data_out_q;
        if (rd_accept) begin
            data_out_d = mem_q[rd_ptr_q];
        end
        data_out = data_out_q;
    end

    // Read data register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for sync_fifo_flags (DEPTH=16, WIDTH=8)
module tb_sync_fifo_flags;

    logic       clk;
    logic       arst_n;
    logic       wr_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       clr_err;

    int n_checks;
    int n_errors;
    logic [7:0] mq[$];
    logic [7:0] exp_d;

    sync_fifo_flags #(
        .WIDTH(8),
        .DEPTH(16),
        .AF_THRESH(14),
        .AE_THRESH(2)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .wr_en(wr_en),
        .data_in(data_in),
        .rd_en(rd_en),
        .data_out(data_out),
        .full(full),
        .empty(empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_empty"}, int'(empty), 1);
        check({tag, "_full"}, int'(full), 0);
        check({tag, "_af"}, int'(almost_full), 0);
        check({tag, "_ae"}, int'(almost_empty), 1);
        check({tag, "_ovf"}, int'(overflow), 0);
        check({tag, "_udf"}, int'(underflow), 0);
        check({tag, "_dout"}, int'(data_out), 0);
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_en   = 1'b1;
        data_in = d;
        mq.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_expect(input string tag);
        logic [7:0] e;
        e = mq.pop_front();
`ifdef FIFO_FWFT_EN
        check(tag, int'(data_out), int'(e));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check(tag, int'(data_out), int'(e));
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arst_n   = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 8'h00;
        clr_err  = 1'b0;
        tick();
        check_reset_state("rst");
        arst_n = 1'b1;
        tick();

        // Fill 0x00..0x0F, flags tracked per written word.
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i));
            check("fill_count", int'(count), i + 1);
            check("fill_af", int'(almost_full), (i + 1 >= 14) ? 1 : 0);
            check("fill_ae", int'(almost_empty), (i + 1 <= 2) ? 1 : 0);
            check("fill_full", int'(full), (i + 1 == 16) ? 1 : 0);
        end

        // Write while full: dropped, overflow set, then cleared.
        wr_en   = 1'b1;
        data_in = 8'hAA;
        tick();
        wr_en = 1'b0;
        check("ovf_set", int'(overflow), 1);
        check("ovf_count", int'(count), 16);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovf_clr", int'(overflow), 0);

        // Drain all 16 in order; 0xAA must never appear.
        for (int i = 0; i < 16; i++) begin
            read_expect("drain_data");
        end
        check("drain_empty", int'(empty), 1);
        check("drain_count", int'(count), 0);
`ifdef FIFO_FWFT_EN
        check("drain_dout", int'(data_out), 0);
`else
        check("drain_dout", int'(data_out), 8'h0F);
`endif

        // Simultaneous write and read at count 5.
        for (int i = 0; i < 5; i++) begin
            write_word(8'h10 + 8'(i));
        end
        check("sim_pre_count", int'(count), 5);
        exp_d = mq.pop_front();
        mq.push_back(8'h55);
`ifdef FIFO_FWFT_EN
        check("sim_data", int'(data_out), int'(exp_d));
`endif
        wr_en   = 1'b1;
        data_in = 8'h55;
        rd_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
        check("sim_data", int'(data_out), int'(exp_d));
`endif
        check("sim_count", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            read_expect("sim_order");
        end
        check("sim_empty", int'(empty), 1);

        // Read while empty: underflow, nothing moves, set beats clear.
        rd_en = 1'b1;
        tick();
        check("udf_set", int'(underflow), 1);
        check("udf_count", int'(count), 0);
`ifdef FIFO_FWFT_EN
        check("udf_dout", int'(data_out), 0);
`else
        check("udf_dout", int'(data_out), 8'h55);
`endif
        clr_err = 1'b1;
        tick();
        check("udf_set_wins", int'(underflow), 1);
        rd_en = 1'b0;
        tick();
        clr_err = 1'b0;
        check("udf_clr", int'(underflow), 0);
        write_word(8'h66);
        read_expect("udf_ptr_stable");

        // 40 writes with 33 overlapped reads: both pointers wrap twice, ending at count 7.
        for (int k = 0; k < 40; k++) begin
            wr_en   = 1'b1;
            data_in = 8'h80 + 8'(k);
            if (k >= 7) begin
                exp_d = mq.pop_front();
                rd_en = 1'b1;
`ifdef FIFO_FWFT_EN
                check("wrap_data", int'(data_out), int'(exp_d));
`endif
            end
            mq.push_back(8'h80 + 8'(k));
            tick();
`ifndef FIFO_FWFT_EN
            if (k >= 7) begin
                check("wrap_data", int'(data_out), int'(exp_d));
            end
`endif
            wr_en = 1'b0;
            rd_en = 1'b0;
        end
        check("wrap_count", int'(count), 7);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        arst_n = 1'b0;
        #2;
        check_reset_state("arst");
        mq.delete();
        tick();
        arst_n = 1'b1;
        tick();
        check_reset_state("post_rst");
        write_word(8'h3C);
        read_expect("post_rst_data");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
